// File: rtl/arb_req_buffer.sv
// arb_req_buffer: three-channel FIFO request buffer feeding a 3-way arbiter, popped words on a shared registered bus
module arb_req_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic [2:0]              push,
  input  logic [3*DATA_WIDTH-1:0] din,
  output logic [2:0]              full,
  output logic [2:0]              req,
  input  logic [2:0]              grant,
  output logic                    bus_valid,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic [1:0]              bus_src,
  output logic [2:0]              overflow,
  output logic                    grant_err
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0] pop, acc;
  logic [3*DATA_WIDTH-1:0] heads;
  logic one_hot, multi;
  assign multi = |(grant & (grant - 3'd1));
  assign one_hot = |grant & ~multi;
  for (genvar c = 0; c < 3; c++) begin : ch
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic ovf;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    assign req[c] = cnt != '0;
    assign full[c] = cnt == (AW+1)'(DEPTH);
    assign pop[c] = grant[c] & req[c] & one_hot;
    // a full channel still accepts a push when it pops in the same cycle
    assign acc[c] = push[c] & (~full[c] | pop[c]);
    assign heads[c*DATA_WIDTH +: DATA_WIDTH] = mem[rp];
    assign overflow[c] = ovf;
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        wp <= wp + AW'(acc[c]);
        rp <= rp + AW'(pop[c]);
        cnt <= cnt + (AW+1)'(acc[c]) - (AW+1)'(pop[c]);
        ovf <= ovf | (push[c] & ~acc[c]);
      end
    end
    always_ff @(posedge clk) begin
      if (acc[c]) mem[wp] <= din[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bus_valid <= 1'b0;
      bus_data <= '0;
      bus_src <= '0;
      grant_err <= 1'b0;
    end else begin
      bus_valid <= |pop;
      grant_err <= grant_err | multi;
      if (|pop) begin
        bus_data <= pop[2] ? heads[2*DATA_WIDTH +: DATA_WIDTH] :
                    pop[1] ? heads[DATA_WIDTH +: DATA_WIDTH] : heads[DATA_WIDTH-1:0];
        bus_src <= pop[2] ? 2'd2 : pop[1] ? 2'd1 : 2'd0;
      end
    end
  end
endmodule

// File: doc/arb_req_buffer.md
Name: arb_req_buffer

Overview:
- Three-channel request buffer that sits directly upstream of the 3-requester arbiter.
- Each channel queues data words from its source in a small FIFO and raises req[i] while the FIFO holds data.
- When the arbiter returns grant[i], the head word of channel i is popped and presented on a shared registered output bus tagged with its source index.

Parameters:
- DATA_WIDTH, 8, width of each queued data word.
- DEPTH, 4, entries per channel FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res_n  input  1  asynchronous active-low reset.
- push  input  3  push[i]=1 writes din slice i into channel i this cycle.
- din  input  3*DATA_WIDTH  channel i data is din[i*DATA_WIDTH +: DATA_WIDTH].
- full  output  3  full[i]=1 when channel i holds DEPTH words.
- req  output  3  req[i]=1 when channel i holds at least 1 word; connects to the arbiter req.
- grant  input  3  one-hot or zero grant from the arbiter.
- bus_valid  output  1  registered; 1 for one cycle per popped word.
- bus_data  output  DATA_WIDTH  registered popped word.
- bus_src  output  2  registered index (0..2) of the channel that supplied bus_data.
- overflow  output  3  sticky; bit i set when a push to channel i was dropped.
- grant_err  output  1  sticky; set when grant had more than one bit high.

Behaviour:
- Reset (res_n=0, asynchronous):
  - all counts and pointers 0; full=0, req=0;
  - bus_valid=0, bus_data=0, bus_src=0, overflow=0, grant_err=0.
  - Reset mid-operation discards all queued words immediately.
- Per-channel FIFO:
  - circular buffer, DEPTH entries;
  - read/write pointers of log2(DEPTH) bits wrap naturally;
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- req[i] and full[i]:
  - combinational from registered count only: req[i]=(count_i!=0), full[i]=(count_i==DEPTH);
  - no combinational path from push or grant to req.
- Pop condition: pop_i = grant[i] & req[i] & (grant is one-hot).
  - grant to an empty channel is ignored: no pop, no bus_valid.
- Push condition: push_i accepted if count_i<DEPTH, or if count_i==DEPTH and pop_i in the same cycle.
  - Otherwise the word is dropped and overflow[i] is set until reset.
- Simultaneous push and pop on one channel: both happen; count unchanged; the pushed word lands behind the existing words.
- Pushing to an empty channel: the word is visible (req[i]=1) the cycle after the push edge. It cannot be popped in the push cycle.
- Output bus:
  - on the edge after a cycle with pop_i: bus_valid=1, bus_data=old head of channel i, bus_src=i.
  - with no pop in a cycle: bus_valid=0 next cycle; bus_data and bus_src hold their last values.
  - Latency grant -> bus_valid = 1 cycle.
- Illegal grant (two or more bits high):
  - no channel pops; grant_err set sticky; bus_valid=0 next cycle.
- Last word popped: count goes to 0 at the pop edge, and req[i] falls in the following cycle.
  - The arbiter may still present a grant[i] in that cycle. It is treated as a grant to an empty channel and ignored.
- Channels are independent. Pushes on all three channels in one cycle are all handled.

Test Plan:
- Reset then idle, grant=000 -> req=000, full=000, bus_valid=0, overflow=000, grant_err=0.
- Push 0xA1, 0xA2 into channel 0; then grant=001 for 2 cycles -> req[0]=1 after the first push edge. bus_valid=1 with bus_data=0xA1, bus_src=0, then 0xA2, bus_src=0. req[0]=0 after the second pop.
- Push DEPTH=4 words 0x10..0x13 into channel 2, then push 0x14 with grant=000 -> full[2]=1 and overflow[2]=1. A later drain with grant=100 yields 0x10, 0x11, 0x12, 0x13 only.
- Channel 1 full (0x20..0x23); in one cycle push 0x24 with grant=010 -> no overflow, full[1] stays 1. Drain order is 0x20, 0x21, 0x22, 0x23, 0x24 (wrap-around exercised).
- Each channel holds one word (0x30, 0x40, 0x50); apply grant=011 -> no pop, bus_valid=0, grant_err=1. Then apply grant=100 -> bus_data=0x50, bus_src=2.
- Channels hold data; assert res_n=0 mid-drain between clock edges -> outputs go to reset values immediately. After release, req=000 and no stale words appear.
